rv32_mdu: RTL and testbench
===========================

# rv32_mdu

Parametrised, multi-cycle integer multiply/divide unit implementing the RISC-V M-extension operations, sitting beside the single-cycle integer ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake and carries a destination tag through unchanged. It returns the result over a second valid/ready handshake. Multiply completes in a fixed short latency; divide/remainder iterate one quotient bit per cycle.

## Interface
- XLEN, 32: operand/result width; must be ≥ 8 and even.
- TAG_W, 5: width of the pass-through tag (destination register index).

- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_op  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_op1, in_op2  in  XLEN  rs1, rs2 values.
- in_tag  in  TAG_W  tag captured with the request.
- kill  in  1  synchronous abort of the in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the returned result.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE: in_valid & in_ready latches op, operands, tag.
  - Ops 0-3 go to MUL.
  - Ops 4-7 with op2 == 0 or signed overflow go to DONE.
  - Other ops 4-7 go to DIV.
- MUL: computes the 2·XLEN product from operands sign/zero-extended per op (MULHSU: op1 signed, op2 unsigned). MUL returns bits [XLEN-1:0]; the others return [2XLEN-1:XLEN]. Next state is DONE.
- DIV: restoring division on magnitudes (|op| for signed ops). One quotient bit per cycle, MSB first. A log2(XLEN)+1-bit counter runs XLEN cycles, then the FSM goes to FIX.
- FIX: sign correction. Quotient is negated if the operand signs differ (signed ops). Remainder takes the sign of the dividend. Next state is DONE.
- Special cases, no iteration:
  - Divide by zero: quotient = all ones; remainder = op1.
  - Signed overflow (op1 = most-negative, op2 = −1, DIV/REM only): quotient = op1; remainder = 0.
- DONE: out_valid = 1. out_result and out_tag are held stable until out_valid & out_ready, then the FSM returns to IDLE.
- kill in any non-IDLE state forces IDLE on the next edge and drops out_valid. No result is returned. kill in IDLE has no effect. kill has priority over out_ready.
- Reset (asynchronous, any state): state = IDLE, counter = 0, out_valid = 0, out_result = 0, out_tag = 0, busy = 0. in_ready = 1 after reset.

## Timing
- Acceptance at edge N:
  - Multiply: out_valid at N+2.
  - Normal divide: out_valid at N+XLEN+2.
  - Special-case divide: out_valid at N+1.
- in_ready is combinational from state only. It has no dependency on in_valid.
- With out_ready held high, the result handshake occurs at the first out_valid edge. The next request is accepted no earlier than the following edge, so multiply issue interval is ≥ 3 cycles.
- Backpressure: DONE persists indefinitely while out_ready = 0, with outputs unchanged.
- kill and out_ready in the same DONE cycle: the kill wins and no transfer is counted.

## Configuration
- RV32_MDU_DIV_EN defined: full behaviour as above.
- RV32_MDU_DIV_EN undefined:
  - DIV/FIX states, the divider datapath and the counter are removed.
  - Ops 4-7 are still accepted, go straight to DONE (out_valid at N+1) and return out_result = 0.
  - Multiply behaviour is unchanged.

## Test plan
- Reset mid-divide (resetn low 1 cycle during DIV) → out_valid = 0, busy = 0, in_ready = 1 immediately.
- Multiply, XLEN = 32:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - Each case: out_valid exactly 2 edges after accept.
- Divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 % 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 % 7 → 2.
  - Each case: out_valid exactly 34 edges after accept.
- Special cases:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - Each case: 1-edge latency.
- Backpressure and tag: hold out_ready = 0 for 10 cycles in DONE → out_result and out_tag (e.g. 0x1A) stable and in_ready = 0 throughout. Raise out_ready → IDLE next edge.
- Kill: assert kill at DIV iteration 10 → IDLE next edge with no out_valid. A following MUL 3 × 4 returns 12 with its own tag.

Source files
------------

// File: rtl/rv32_mdu.sv
// RV32 M-extension multiply/divide unit, valid/ready in and out, tag pass-through.
// Define RV32_MDU_DIV_EN to build the iterative divider; otherwise ops 4-7 return 0.
module rv32_mdu #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

`ifdef RV32_MDU_DIV_EN
  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
  } state_t;
  localparam int CW = $clog2(XLEN) + 1;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DONE
  } state_t;
`endif

  state_t            r_state, w_next;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_a, r_b, r_res;
  logic [TAG_W-1:0]  r_tag;
  logic              w_sa, w_sb, w_hold;
  logic [2*XLEN-1:0] w_ma, w_mb, w_prod;

  // MUL low half is sign-agnostic; MULH both signed, MULHSU op1 only
  assign w_sa   = (r_op == 2'd1) || (r_op == 2'd2);
  assign w_sb   = (r_op == 2'd1);
  assign w_ma   = {{XLEN{w_sa & r_a[XLEN-1]}}, r_a};
  assign w_mb   = {{XLEN{w_sb & r_b[XLEN-1]}}, r_b};
  assign w_prod = w_ma * w_mb;
  assign w_hold = kill && (r_state != S_IDLE);

`ifdef RV32_MDU_DIV_EN
  logic [XLEN-1:0] r_rem;
  logic [CW-1:0]   r_cnt;
  logic            r_negq, r_negr;
  logic            w_sdiv, w_zero, w_ovf, w_neg1, w_neg2, w_ge;
  logic [XLEN-1:0] w_abs1, w_abs2, w_rem_n, w_quo_n;
  logic [XLEN:0]   w_sh, w_diff;

  assign w_sdiv  = ~in_op[0];
  assign w_zero  = (in_op2 == '0);
  assign w_ovf   = w_sdiv && (in_op1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (in_op2 == '1);
  assign w_neg1  = w_sdiv & in_op1[XLEN-1];
  assign w_neg2  = w_sdiv & in_op2[XLEN-1];
  assign w_abs1  = w_neg1 ? -in_op1 : in_op1;
  assign w_abs2  = w_neg2 ? -in_op2 : in_op2;
  // r_a doubles as the dividend/quotient shift register
  assign w_sh    = {r_rem, r_a[XLEN-1]};
  assign w_diff  = w_sh - {1'b0, r_b};
  assign w_ge    = ~w_diff[XLEN];
  assign w_rem_n = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
  assign w_quo_n = {r_a[XLEN-2:0], w_ge};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (!in_op[2]) w_next = S_MUL;
`ifdef RV32_MDU_DIV_EN
          else if (w_zero || w_ovf) w_next = S_DONE;
          else w_next = S_DIV;
`else
          else w_next = S_DONE;
`endif
        end
      end
      S_MUL: w_next = S_DONE;
`ifdef RV32_MDU_DIV_EN
      S_DIV: if (r_cnt == CW'(XLEN-1)) w_next = S_FIX;
      S_FIX: w_next = S_DONE;
`endif
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_hold) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_tag <= '0;
      r_res <= '0;
`ifdef RV32_MDU_DIV_EN
      r_rem  <= '0;
      r_cnt  <= '0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
`endif
    end else if (!w_hold) begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= in_op[1:0];
            r_tag <= in_tag;
            r_a   <= in_op1;
            r_b   <= in_op2;
`ifdef RV32_MDU_DIV_EN
            r_rem  <= '0;
            r_cnt  <= '0;
            r_negq <= w_neg1 ^ w_neg2;
            r_negr <= w_neg1;
            if (in_op[2]) begin
              r_a <= w_abs1;
              r_b <= w_abs2;
              if (w_zero)     r_res <= in_op[1] ? in_op1 : '1;
              else if (w_ovf) r_res <= in_op[1] ? '0 : in_op1;
            end
`else
            if (in_op[2]) r_res <= '0;
`endif
          end
        end
        S_MUL: r_res <= (r_op == 2'd0) ? w_prod[XLEN-1:0]
                                       : w_prod[2*XLEN-1:XLEN];
`ifdef RV32_MDU_DIV_EN
        S_DIV: begin
          r_rem <= w_rem_n;
          r_a   <= w_quo_n;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: r_res <= r_op[1] ? (r_negr ? -r_rem : r_rem)
                                : (r_negq ? -r_a : r_a);
`endif
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_res;
  assign out_tag    = r_tag;

endmodule

// File: tb/tb_rv32_mdu.sv
// Bench for rv32_mdu: vector table with result scoreboard,
// plus backpressure, kill and mid-operation reset sequences.
module tb_rv32_mdu;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
`ifdef RV32_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [XLEN-1:0]  in_op1 = '0, in_op2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             kill = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  always #5 clk = ~clk;

  rv32_mdu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_op1(in_op1), .in_op2(in_op2),
    .in_tag(in_tag), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .busy(busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[18];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] tag,
                              input logic [31:0] exp, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag;
    v.exp = op[2] && !DIV_EN ? 32'h0 : exp;
    v.lat = op[2] && !DIV_EN ? 1 : lat;
    return v;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    @(posedge clk); #1;
    in_op = op; in_op1 = a; in_op2 = b; in_tag = tag;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_result(input string nm, input int lat_exp);
    int lat;
    exp_t e;
    wait_valid(lat);
    chk({nm, "_lat"}, lat, lat_exp);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({nm, "_res"}, out_result, e.res);
      chk({nm, "_tag"}, {27'd0, out_tag}, {27'd0, e.tag});
    end else begin
      chk({nm, "_sb"}, 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    chk({nm, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run(input vec_t v, input string nm);
    exp_t e;
    e.res = v.exp; e.tag = v.tag;
    sb.push_back(e);
    issue(v.op, v.a, v.b, v.tag);
    wait_result(nm, v.lat);
  endtask

  initial begin
    int lat, hits;
    vecs[0]  = mk(3'd0, 32'h7,        32'hFFFFFFFD, 5'h01, 32'hFFFFFFEB, 2);
    vecs[1]  = mk(3'd1, 32'h80000000, 32'h80000000, 5'h02, 32'h40000000, 2);
    vecs[2]  = mk(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 32'hFFFFFFFE, 2);
    vecs[3]  = mk(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h04, 32'hFFFFFFFF, 2);
    vecs[4]  = mk(3'd1, 32'hFFFFFFFF, 32'h2,        5'h05, 32'hFFFFFFFF, 2);
    vecs[5]  = mk(3'd4, 32'hFFFFFFF9, 32'h2,        5'h06, 32'hFFFFFFFD, 34);
    vecs[6]  = mk(3'd6, 32'hFFFFFFF9, 32'h2,        5'h07, 32'hFFFFFFFF, 34);
    vecs[7]  = mk(3'd5, 32'd100,      32'd7,        5'h08, 32'd14,       34);
    vecs[8]  = mk(3'd7, 32'd100,      32'd7,        5'h09, 32'd2,        34);
    vecs[9]  = mk(3'd4, 32'd5,        32'd0,        5'h0A, 32'hFFFFFFFF, 1);
    vecs[10] = mk(3'd7, 32'd5,        32'd0,        5'h0B, 32'd5,        1);
    vecs[11] = mk(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'h0C, 32'h80000000, 1);
    vecs[12] = mk(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'h0D, 32'h0,        1);
    vecs[13] = mk(3'd5, 32'h80000000, 32'hFFFFFFFF, 5'h0E, 32'h0,        34);
    vecs[14] = mk(3'd4, 32'h80000000, 32'd3,        5'h0F, 32'hD5555556, 34);
    vecs[15] = mk(3'd6, 32'h80000000, 32'd3,        5'h10, 32'hFFFFFFFE, 34);
    vecs[16] = mk(3'd5, 32'd5,        32'd0,        5'h11, 32'hFFFFFFFF, 1);
    vecs[17] = mk(3'd0, 32'h12345678, 32'h10,       5'h1F, 32'h23456780, 2);

    #3;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_ready", {31'd0, in_ready},  32'd1);
    chk("rst_res",   out_result,         32'd0);
    chk("rst_tag",   {27'd0, out_tag},   32'd0);
    #9 resetn = 1'b1;

    for (int i = 0; i < 18; i++)
      run(vecs[i], $sformatf("v%0d", i));

    // backpressure: result and tag must hold while out_ready is low
    out_ready = 1'b0;
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h1A);
    wait_valid(lat);
    chk("bp_lat", lat, 2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_res%0d", i), out_result, 32'hFFFFFFFE);
      chk($sformatf("bp_tag%0d", i), {27'd0, out_tag}, 32'h1A);
      chk($sformatf("bp_rdy%0d", i), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_vld%0d", i), {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_rdy", {31'd0, in_ready}, 32'd1);
    chk("bp_rel_vld", {31'd0, out_valid}, 32'd0);

    // kill mid-operation: iteration 10 of a divide, or the MUL cycle
    if (DIV_EN) begin
      issue(3'd5, 32'd100, 32'd7, 5'h03);
      repeat (9) @(posedge clk);
      #1;
    end else begin
      issue(3'd0, 32'd9, 32'd9, 5'h03);
    end
    chk("kill_busy_pre", {31'd0, busy}, 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_vld",  {31'd0, out_valid}, 32'd0);
    chk("kill_rdy",  {31'd0, in_ready},  32'd1);
    chk("kill_busy", {31'd0, busy},      32'd0);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) hits++;
      @(posedge clk); #1;
    end
    chk("kill_noresult", hits, 0);

    // kill beats out_ready in DONE
    out_ready = 1'b0;
    issue(3'd0, 32'd5, 32'd5, 5'h09);
    wait_valid(lat);
    chk("kd_lat", lat, 2);
    kill = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kd_vld", {31'd0, out_valid}, 32'd0);
    chk("kd_rdy", {31'd0, in_ready},  32'd1);

    run(mk(3'd0, 32'd3, 32'd4, 5'h15, 32'd12, 2), "post_kill");

    // kill in IDLE must not block acceptance
    @(posedge clk); #1;
    in_op = 3'd0; in_op1 = 32'd6; in_op2 = 32'd7; in_tag = 5'h16;
    in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    chk("idle_kill_busy", {31'd0, busy}, 32'd1);
    begin
      exp_t e;
      e.res = 32'd42; e.tag = 5'h16;
      sb.push_back(e);
    end
    wait_result("idle_kill", 2);

    // asynchronous reset in the middle of an operation
    if (DIV_EN) begin
      issue(3'd4, 32'd1000, 32'd3, 5'h12);
      repeat (5) @(posedge clk);
      #1;
    end else begin
      issue(3'd0, 32'd2, 32'd3, 5'h12);
    end
    resetn = 1'b0;
    #1;
    chk("mr_vld",  {31'd0, out_valid}, 32'd0);
    chk("mr_busy", {31'd0, busy},      32'd0);
    chk("mr_rdy",  {31'd0, in_ready},  32'd1);
    chk("mr_res",  out_result,         32'd0);
    chk("mr_tag",  {27'd0, out_tag},   32'd0);
    #2 resetn = 1'b1;

    run(mk(3'd7, 32'd100, 32'd7, 5'h13, 32'd2, 34), "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
